serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder built around the single-bit full-adder cell.

---
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder slice
// with a registered carry, and the sum is reassembled in a shift register.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, a_sr_nx;
   logic [WIDTH-1:0] b_sr, b_sr_nx;
   logic [WIDTH-1:0] s_sr, s_sr_nx;
   logic             c, c_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             busy_nx, done_nx, cout_nx;
   logic [WIDTH-1:0] sum_nx;

   // Full-adder slice on the current LSBs and the sum register after this bit is inserted
   logic             bit_s, bit_c;
   logic [WIDTH-1:0] s_sr_shift;

   assign bit_s = a_sr[0] ^ b_sr[0] ^ c;
   assign bit_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);

   generate
      if (WIDTH == 1) begin : g_narrow
         assign s_sr_shift = bit_s;
      end else begin : g_wide
         assign s_sr_shift = {bit_s, s_sr[WIDTH-1:1]};
      end
   endgenerate

   // Next-state and next-output logic
   always_comb begin
      state_nx = state;
      a_sr_nx  = a_sr;
      b_sr_nx  = b_sr;
      s_sr_nx  = s_sr;
      c_nx     = c;
      cnt_nx   = cnt;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      sum_nx   = sum;
      cout_nx  = cout;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = SHIFT;
               a_sr_nx  = a;
               b_sr_nx  = b;
               c_nx     = cin;
               cnt_nx   = '0;
               busy_nx  = 1'b1;
            end
         end
         SHIFT: begin
            busy_nx = 1'b1;
            c_nx    = bit_c;
            s_sr_nx = s_sr_shift;
            a_sr_nx = a_sr >> 1;
            b_sr_nx = b_sr >> 1;
            cnt_nx  = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               state_nx = DONE;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
               sum_nx   = s_sr_shift;
               cout_nx  = bit_c;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         s_sr  <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= state_nx;
         a_sr  <= a_sr_nx;
         b_sr  <= b_sr_nx;
         s_sr  <= s_sr_nx;
         c     <= c_nx;
         cnt   <= cnt_nx;
         busy  <= busy_nx;
         done  <= done_nx;
         sum   <= sum_nx;
         cout  <= cout_nx;
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random adds at WIDTH=8,
// exhaustive adds at WIDTH=3, compared against plain integer addition.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;

   logic       start;
   logic [7:0] a, b;
   logic       cin;
   logic       busy, done;
   logic [7:0] sum;
   logic       cout;

   logic       start3;
   logic [2:0] a3, b3;
   logic       cin3;
   logic       busy3, done3;
   logic [2:0] sum3;
   logic       cout3;

   int         n_asserts;
   int         n_fail;
   logic [8:0] prev;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder #(.WIDTH(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
      .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 add; poke raises start (a=F0) mid-SHIFT and in the DONE cycle
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input bit poke);
      int         k;
      logic [8:0] exp;
      exp = 9'(ia) + 9'(ib) + 9'(ic);
      @(negedge clk);
      a = ia; b = ib; cin = ic; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      chk("busy_after_accept", 64'(busy), 64'(1));
      chk("done_after_accept", 64'(done), 64'(0));
      k = 0;
      while (!done && k < 20) begin
         if (poke && k == 2) begin
            start = 1'b1; a = 8'hF0;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         k++;
         if (!done) begin
            chk("busy_in_shift", 64'(busy), 64'(1));
            chk("sum_held", 64'({cout, sum}), 64'(prev));
         end
      end
      chk("latency8", 64'(k), 64'(8));
      chk("result8", 64'({cout, sum}), 64'(exp));
      chk("busy_with_done", 64'(busy), 64'(0));
      start = poke;
      if (poke) a = 8'hF0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("busy_after_done", 64'(busy), 64'(0));
      chk("result_held", 64'({cout, sum}), 64'(exp));
      @(posedge clk); #1;
      chk("no_queued_start", 64'(busy), 64'(0));
      prev = exp;
   endtask

   // One WIDTH=3 add: latency and result
   task automatic run3(input logic [2:0] ia, input logic [2:0] ib, input logic ic);
      int         k;
      logic [3:0] exp;
      exp = 4'(ia) + 4'(ib) + 4'(ic);
      @(negedge clk);
      a3 = ia; b3 = ib; cin3 = ic; start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      k = 0;
      while (!done3 && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      chk("latency3", 64'(k), 64'(3));
      chk("result3", 64'({cout3, sum3}), 64'(exp));
      @(posedge clk); #1;
   endtask

   initial begin
      bit seen_done;
      n_asserts = 0;
      n_fail    = 0;
      prev      = '0;
      rst_n = 1'b0;
      start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;

      // Reset state, with start asserted to confirm reset wins
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_sum", 64'({cout, sum}), 64'(0));
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_busy", 64'(busy), 64'(0));

      // Directed cases
      run8(8'h5A, 8'h3C, 1'b0, 1'b0);
      run8(8'hFF, 8'h01, 1'b0, 1'b0);
      run8(8'hFF, 8'hFF, 1'b1, 1'b0);
      run8(8'h01, 8'h01, 1'b0, 1'b1);

      // Abort mid-operation
      @(negedge clk);
      a = 8'h77; b = 8'h11; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_sum", 64'({cout, sum}), 64'(0));
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done || busy) seen_done = 1'b1;
      end
      chk("abort_no_done", 64'(seen_done), 64'(0));
      prev = '0;
      run8(8'h10, 8'h20, 1'b0, 1'b0);

      // Random operands against integer addition
      for (int i = 0; i < 20; i++) begin
         run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      end

      // Exhaustive WIDTH=3
      for (int x = 0; x < 8; x++) begin
         for (int y = 0; y < 8; y++) begin
            for (int z = 0; z < 2; z++) begin
               run3(3'(x), 3'(y), 1'(z));
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
